// File: rtl/slot_tx_buffer.sv
// slot_tx_buffer: per-slot store-and-forward egress buffer; forwards good packets
// to XAUI one word per cycle and silently drops packets flagged invalid.
module slot_tx_buffer #(
    parameter int DATA_AW         = 8,
    parameter int VALID_AW        = 6,
    parameter int AF_THRESHOLD    = 128,
    parameter int VALID_AF_MARGIN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [133:0] in_slot_pkt,
    input  logic         in_slot_pkt_wr,
    input  logic         in_slot_pkt_valid,
    input  logic         in_slot_pkt_valid_wr,
    output logic         out_slot_pkt_almostfull,
    output logic [133:0] out_xaui_pkt,
    output logic         out_xaui_pkt_wr,
    input  logic         in_xaui_almostfull,
    output logic         slot_send_pkt_add,
    output logic         slot_discard_pkt_add,
    output logic         slot_overflow_add
);
    localparam int DD = 1 << DATA_AW;
    localparam int VD = 1 << VALID_AW;

    typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

    state_t                state_q;
    logic [133:0]          dmem [DD];
    logic                  vmem [VD];
    logic [DATA_AW-1:0]    dwp_q, drp_q;
    logic [VALID_AW-1:0]   vwp_q, vrp_q;
    logic [DATA_AW:0]      dcnt_q, dcnt_d;
    logic [VALID_AW:0]     vcnt_q, vcnt_d;
    logic [133:0]          dhead;
    logic                  vhead, dpush, vpush, dpop, vpop, is_tail;
    logic [133:0]          pkt_q;
    logic                  wr_q, send_q, disc_q, ovf_q;

    // Occupancy counters reach exactly the depth, so their MSB is the full flag.
    always_comb begin
        dhead   = dmem[drp_q];
        vhead   = vmem[vrp_q];
        is_tail = dhead[133:132] == 2'b10;
        dpush   = in_slot_pkt_wr & ~dcnt_q[DATA_AW];
        vpush   = in_slot_pkt_valid_wr & ~vcnt_q[VALID_AW];
        dpop    = (state_q != IDLE) && (dcnt_q != '0);
        vpop    = (state_q == IDLE) && (vcnt_q != '0) && (~vhead | ~in_xaui_almostfull);
        dcnt_d  = dcnt_q + (DATA_AW+1)'(dpush) - (DATA_AW+1)'(dpop);
        vcnt_d  = vcnt_q + (VALID_AW+1)'(vpush) - (VALID_AW+1)'(vpop);
    end

    assign out_slot_pkt_almostfull = (dcnt_q >= (DATA_AW+1)'(AF_THRESHOLD)) |
        (((VALID_AW+1)'(VD) - vcnt_q) <= (VALID_AW+1)'(VALID_AF_MARGIN));
    assign out_xaui_pkt         = pkt_q;
    assign out_xaui_pkt_wr      = wr_q;
    assign slot_send_pkt_add    = send_q;
    assign slot_discard_pkt_add = disc_q;
    assign slot_overflow_add    = ovf_q;

    always_ff @(posedge clk) begin
        if (dpush) dmem[dwp_q] <= in_slot_pkt;
        if (vpush) vmem[vwp_q] <= in_slot_pkt_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwp_q  <= '0;
            drp_q  <= '0;
            vwp_q  <= '0;
            vrp_q  <= '0;
            dcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            dwp_q  <= dwp_q + DATA_AW'(dpush);
            drp_q  <= drp_q + DATA_AW'(dpop);
            vwp_q  <= vwp_q + VALID_AW'(vpush);
            vrp_q  <= vrp_q + VALID_AW'(vpop);
            dcnt_q <= dcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            wr_q    <= 1'b0;
            send_q  <= 1'b0;
            disc_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pkt_q  <= '0;
            wr_q   <= 1'b0;
            send_q <= 1'b0;
            disc_q <= 1'b0;
            ovf_q  <= (in_slot_pkt_wr & dcnt_q[DATA_AW]) | (in_slot_pkt_valid_wr & vcnt_q[VALID_AW]);
            case (state_q)
                IDLE: if (vpop) state_q <= vhead ? SEND : DROP;
                SEND: if (dpop) begin
                    pkt_q <= dhead;
                    wr_q  <= 1'b1;
                    if (is_tail) begin
                        send_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DROP: if (dpop && is_tail) begin
                    disc_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slot_tx_buffer.sv
// tb_slot_tx_buffer: randomized and directed scoreboard bench for slot_tx_buffer.
module tb_slot_tx_buffer;
    logic         clk = 1'b0;
    logic         reset;
    logic [133:0] pkt;
    logic         pkt_wr, vld, vld_wr, xaf;
    logic         af, owr, sadd, dadd, oadd;
    logic [133:0] opkt;

    slot_tx_buffer dut (
        .clk(clk), .reset(reset),
        .in_slot_pkt(pkt), .in_slot_pkt_wr(pkt_wr),
        .in_slot_pkt_valid(vld), .in_slot_pkt_valid_wr(vld_wr),
        .out_slot_pkt_almostfull(af),
        .out_xaui_pkt(opkt), .out_xaui_pkt_wr(owr),
        .in_xaui_almostfull(xaf),
        .slot_send_pkt_add(sadd), .slot_discard_pkt_add(dadd), .slot_overflow_add(oadd)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0, cyc = 0;
    int n_wr = 0, n_send = 0, n_disc = 0, n_ovf = 0;
    int exp_send = 0, exp_disc = 0, exp_ovf = 0;
    int flag_cyc = 0, lat_got = 0, last_wr = -1;
    bit lat_arm = 0, gap_on = 0;
    logic [133:0] expq [$];
    logic [133:0] cur [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every forwarded word must be the next expected one.
    always @(negedge clk) begin
        if (owr) begin
            n_wr++;
            if (lat_arm) begin
                lat_got = cyc;
                lat_arm = 0;
            end
            if (expq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL extra_word: got %h expected none", opkt);
            end else begin
                logic [133:0] e;
                e = expq.pop_front();
                chk("word", opkt, e);
                chk_int("send_pulse", int'(sadd), int'(e[133:132] == 2'b10));
            end
            if (gap_on && last_wr >= 0) chk_int("gap", cyc - last_wr, 2);
            last_wr = cyc;
        end else begin
            chk("idle_data", opkt, '0);
            chk_int("idle_send", int'(sadd), 0);
        end
        if (sadd) n_send++;
        if (dadd) n_disc++;
        if (oadd) n_ovf++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pkt_wr = 1'b0;
        vld_wr = 1'b0;
        pkt    = '0;
    endtask

    task automatic set_flag(input bit good);
        vld      = good;
        vld_wr   = 1'b1;
        flag_cyc = cyc;
        if (good) begin
            foreach (cur[i]) expq.push_back(cur[i]);
            exp_send++;
        end else exp_disc++;
    endtask

    task automatic put_pkt(input int len, input bit good, input int fd);
        cur.delete();
        for (int i = 0; i < len; i++) begin
            logic [1:0] h;
            h = (i == len - 1) ? 2'b10 : (i == 0) ? 2'b01 : 2'b11;
            cur.push_back({h, $urandom(), $urandom(), $urandom(), $urandom(), 4'(i)});
        end
        for (int i = 0; i < len; i++) begin
            tick();
            pkt    = cur[i];
            pkt_wr = 1'b1;
            if (i == len - 1 && fd == 0) set_flag(good);
        end
        if (fd > 0) begin
            repeat (fd) tick();
            tick();
            set_flag(good);
        end
    endtask

    task automatic raw_words(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            pkt    = {2'b10, $urandom(), $urandom(), $urandom(), $urandom(), 4'h0};
            pkt_wr = 1'b1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        if (expq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", expq.size());
            expq.delete();
        end
        repeat (40) tick();
    endtask

    task automatic wait_n_wr(input int target);
        int t = 0;
        while (n_wr < target && t < 100) begin
            tick();
            t++;
        end
        if (n_wr < target) begin
            nvec++;
            nerr++;
            $display("FAIL wait_output: got %0d words expected %0d", n_wr, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int base, d;
        reset = 1'b1; pkt = '0; pkt_wr = 0; vld = 0; vld_wr = 0; xaf = 0;
        repeat (2) tick();
        chk_int("rst_wr", int'(owr), 0);
        chk("rst_pkt", opkt, '0);
        chk_int("rst_send", int'(sadd), 0);
        chk_int("rst_disc", int'(dadd), 0);
        chk_int("rst_ovf", int'(oadd), 0);
        chk_int("rst_af", int'(af), 0);
        reset = 1'b0;
        tick();

        lat_arm = 1;
        put_pkt(4, 1, 0);
        drain();
        chk_int("first_latency", lat_got - flag_cyc, 3);
        chk_int("send_cnt_1", n_send, exp_send);

        put_pkt(3, 0, 0);
        put_pkt(2, 1, 2);
        drain();
        chk_int("disc_cnt_2", n_disc, exp_disc);
        chk_int("send_cnt_2", n_send, exp_send);

        xaf = 1'b1;
        put_pkt(6, 1, 0);
        base = n_wr;
        repeat (20) tick();
        chk_int("bp_hold", n_wr - base, 0);
        lat_arm = 1;
        tick();
        xaf = 1'b0;
        d = cyc;
        wait_n_wr(base + 1);
        xaf = 1'b1;
        drain();
        chk_int("bp_release", lat_got - d, 2);
        chk_int("bp_words", n_wr - base, 6);
        xaf = 1'b0;

        base = n_ovf;
        raw_words(127);
        tick();
        chk_int("af_127", int'(af), 0);
        raw_words(1);
        tick();
        chk_int("af_128", int'(af), 1);
        raw_words(132);
        tick();
        tick();
        exp_ovf += 4;
        chk_int("overflow_pulses", n_ovf - base, 4);
        chk_int("af_full", int'(af), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk_int("af_after_reset", int'(af), 0);

        xaf = 1'b1;
        for (int i = 0; i < 59; i++) put_pkt(1, 1, 0);
        tick();
        chk_int("af_59_flags", int'(af), 0);
        put_pkt(1, 1, 0);
        tick();
        chk_int("af_60_flags", int'(af), 1);
        base = n_send;
        gap_on = 1;
        last_wr = -1;
        xaf = 1'b0;
        drain();
        gap_on = 0;
        chk_int("send_60", n_send - base, 60);

        put_pkt(8, 1, 0);
        base = n_wr;
        wait_n_wr(base + 4);
        reset = 1'b1;
        tick();
        chk_int("midrst_wr", int'(owr), 0);
        chk("midrst_pkt", opkt, '0);
        chk_int("midrst_send", int'(sadd), 0);
        chk_int("midrst_af", int'(af), 0);
        expq.delete();
        exp_send--;
        reset = 1'b0;
        tick();
        put_pkt(5, 1, 0);
        drain();
        chk_int("send_after_rst", n_send, exp_send);

        for (int p = 0; p < 80; p++) begin
            int t = 0;
            xaf = 1'b0;
            while (af && t < 500) begin
                tick();
                t++;
            end
            if (af) begin
                nvec++;
                nerr++;
                $display("FAIL af_stuck: got 1 expected 0");
            end
            xaf = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) tick();
            put_pkt($urandom_range(1, 8), $urandom_range(0, 9) < 7, $urandom_range(0, 3));
        end
        xaf = 1'b0;
        drain();
        chk_int("final_send", n_send, exp_send);
        chk_int("final_disc", n_disc, exp_disc);
        chk_int("final_ovf", n_ovf, exp_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/slot_tx_buffer.md
# slot_tx_buffer

Per-slot store-and-forward egress buffer placed directly downstream of the egress output controller, one instance per slot. Accepts a slot's 134-bit packet stream plus its per-packet valid flag, buffers whole packets, forwards good packets to the slot's XAUI transmit interface one word per cycle, and silently drops packets flagged invalid. Provides almost-full back-pressure to the output controller and single-cycle statistics pulses.

## Interface
Parameters:
- DATA_AW, 8, address width of data FIFO (depth 2^DATA_AW = 256 words)
- VALID_AW, 6, address width of valid FIFO (depth 64 packets)
- AF_THRESHOLD, 128, data FIFO occupancy at/above which almost-full asserts
- VALID_AF_MARGIN, 4, valid FIFO free-entry count at/below which almost-full asserts

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- in_slot_pkt  in  134  packet word; [133:132] = 01 head, 11 middle, 10 tail
- in_slot_pkt_wr  in  1  write strobe for in_slot_pkt
- in_slot_pkt_valid  in  1  packet good (1) / discard (0)
- in_slot_pkt_valid_wr  in  1  strobe for in_slot_pkt_valid, one per packet, coincident with or after tail word
- out_slot_pkt_almostfull  out  1  back-pressure to upstream
- out_xaui_pkt  out  134  forwarded word
- out_xaui_pkt_wr  out  1  forwarded-word strobe
- in_xaui_almostfull  in  1  downstream back-pressure
- slot_send_pkt_add  out  1  pulse per packet forwarded
- slot_discard_pkt_add  out  1  pulse per invalid packet dropped
- slot_overflow_add  out  1  pulse per input word or flag lost to full FIFO

## Operation
- Two internal show-ahead FIFOs (head entry visible without read): data FIFO (134b x 2^DATA_AW) and valid FIFO (1b x 2^VALID_AW). Behavioural RTL, no vendor IP.
- Writes: in_slot_pkt_wr pushes word unless data FIFO full; in_slot_pkt_valid_wr pushes flag unless valid FIFO full. Dropped push -> slot_overflow_add high next cycle. Simultaneous read and write on a full FIFO: write is dropped (full evaluated before read).
- out_slot_pkt_almostfull = (data count >= AF_THRESHOLD) | (valid free entries <= VALID_AF_MARGIN), combinational from registered counts.
- FSM states: IDLE, SEND, DROP.
  - IDLE: if valid FIFO non-empty: flag=1 and in_xaui_almostfull=0 -> pop flag, go SEND; flag=1 and in_xaui_almostfull=1 -> stay; flag=0 -> pop flag, go DROP (no downstream check). Else stay.
  - SEND: each cycle pop data head, register to out_xaui_pkt with out_xaui_pkt_wr=1. If popped word is tail (10): pulse slot_send_pkt_add, go IDLE. in_xaui_almostfull ignored mid-packet.
  - DROP: pop data head each cycle, no output; on tail pulse slot_discard_pkt_add, go IDLE.
  - SEND/DROP with data FIFO empty (upstream violation): no pop, no strobe, hold state.
- Counts wrap-free: occupancy counters DATA_AW+1 / VALID_AW+1 bits, pointers wrap modulo depth.

## Timing
- Reset (sync, one cycle): FIFOs emptied, FSM IDLE, out_xaui_pkt=0, out_xaui_pkt_wr=0, all *_add=0, out_slot_pkt_almostfull=0. Reset mid-packet abandons the partial packet; no tail emitted.
- Flag pushed cycle N -> visible cycle N+1 -> IDLE decides in N+1 -> first out_xaui_pkt_wr in N+2.
- Throughput one word/cycle in SEND; one IDLE cycle between consecutive packets (tail cycle -> IDLE -> next first word two cycles after tail output).
- Pulse outputs are exactly one cycle wide, registered, aligned with the cycle out_xaui_pkt_wr carries the tail (send) or one cycle after the tail pop (discard, overflow).
- out_xaui_pkt holds last value when out_xaui_pkt_wr=0? No: driven to 0 whenever out_xaui_pkt_wr=0.

## Test plan
- 4-word good packet (01,11,11,10), valid=1 written with tail at cycle 10 -> out_xaui_pkt_wr high cycles 12-15, identical words, slot_send_pkt_add high cycle 15.
- 3-word packet with valid=0 followed by 2-word good packet -> no output for first, slot_discard_pkt_add one pulse, second packet output intact, one send pulse.
- in_xaui_almostfull=1 while good packet queued for 20 cycles -> no output; deassert -> output starts 1 cycle later; assertion mid-packet does not stall it.
- Write 130 words without flags -> out_slot_pkt_almostfull high once count reaches 128; write 260 words -> 4 slot_overflow_add pulses, FIFO holds 256.
- 60 back-to-back 1-word (tail-only) good packets -> almostfull asserts at 60 flags queued; all 60 forwarded, 60 send pulses, gap of one cycle between each.
- Assert reset during SEND of 8-word packet at word 4 -> next cycle all outputs 0, FIFOs empty; subsequent packet forwards normally.
